// File: rtl/vga_fb_pkg.sv
// vga_fb_pkg: shared definitions for the VGA framebuffer arbiter.
//   PIX_W            - width of one 4:4:4 RGB pixel word
//   FRAME_PIXELS_DEF - default pixels fetched per frame (640x480)
//   fb_state_e       - arbiter FSM encoding (FLUSH, PREFILL, RUN, DONE)
package vga_fb_pkg;

  localparam int PIX_W            = 12;
  localparam int FRAME_PIXELS_DEF = 307200;

  typedef enum logic [1:0] {
    ST_FLUSH   = 2'd0,
    ST_PREFILL = 2'd1,
    ST_RUN     = 2'd2,
    ST_DONE    = 2'd3
  } fb_state_e;

endpackage

// File: rtl/vga_pix_fifo.sv
// vga_pix_fifo: synchronous DEPTH x PIX_W pixel prefetch FIFO.
// Ports:
//   clk, rst       - clock, asynchronous active-high reset
//   flush_i        - empty the FIFO; wins over a push in the same cycle
//   push_i, din_i  - write one pixel (caller guarantees not full)
//   pop_i          - drop the head entry (caller guarantees not empty)
//   head_o         - current head entry
//   level_o        - number of stored entries (0..DEPTH)
//   empty_o        - level_o == 0
module vga_pix_fifo
  import vga_fb_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [PIX_W-1:0]         din_i,
  input  logic                     pop_i,
  output logic [PIX_W-1:0]         head_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [PIX_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    count_d = count_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Storage needs no reset; only entries below the level are ever read.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= din_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign level_o = count_q;
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares one single-port framebuffer RAM between the linear
// display prefetch path and a demo-effect writer, and feeds VGAcore one pixel
// per pix_pop from a small prefetch FIFO.
// Ports:
//   clk_25_175, reset          - pixel clock, asynchronous active-high reset
//   frame_start                - restart fetch at address 0, flush FIFO
//   pix_pop / pixstream        - pixel consume strobe / registered pixel out
//   underrun                   - sticky flag: pop of an empty FIFO this frame
//   wr_req/wr_addr/wr_data     - writer request; wr_gnt accepts it (comb.)
//   mem_*                      - single-port RAM interface, rdata 1 cycle late
//   underrun_cnt               - empty-pop counter (FB_UNDERRUN_COUNT_EN only)
//   dbg_state, dbg_level       - FSM state and FIFO level for observation
// Optional feature macro: FB_UNDERRUN_COUNT_EN.
//
// Writer handshake: wr_req is a valid; wr_gnt is its ready. The writer holds
// wr_req, wr_addr and wr_data stable until a cycle in which wr_gnt is high;
// that cycle the write is driven onto the RAM and the request is consumed.
module vga_fb_arbiter
  import vga_fb_pkg::*;
#(
  parameter int               ADDR_W         = 19,
  parameter int               FRAME_PIXELS   = FRAME_PIXELS_DEF,
  parameter int               FIFO_DEPTH     = 8,
  parameter int               LOW_WATER      = 2,
  parameter logic [PIX_W-1:0] UNDERRUN_COLOR = 12'h000
) (
  input  logic                          clk_25_175,
  input  logic                          reset,
  input  logic                          frame_start,
  input  logic                          pix_pop,
  output logic [PIX_W-1:0]              pixstream,
  output logic                          underrun,
  input  logic                          wr_req,
  input  logic [ADDR_W-1:0]             wr_addr,
  input  logic [PIX_W-1:0]              wr_data,
  output logic                          wr_gnt,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic                          mem_rd_en,
  output logic                          mem_wr_en,
  output logic [PIX_W-1:0]              mem_wdata,
  input  logic [PIX_W-1:0]              mem_rdata,
`ifdef FB_UNDERRUN_COUNT_EN
  output logic [15:0]                   underrun_cnt,
`endif
  output fb_state_e                     dbg_state,
  output logic [$clog2(FIFO_DEPTH):0]   dbg_level
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  fb_state_e         state_q, state_d;
  logic [ADDR_W-1:0] fetch_addr_q;
  logic              inflight_q;
  logic [PIX_W-1:0]  pix_q;
  logic              underrun_q;

  logic [LW-1:0]     fifo_level;
  logic [PIX_W-1:0]  fifo_head;
  logic              fifo_empty;
  logic [LW-1:0]     credit;
  logic              can_fetch;
  logic              rd_en, gnt;
  logic              last_fetch;

  // Return data is pushed when it arrives; a frame_start flush in the arrival
  // cycle wins inside the FIFO, which is how stale reads get discarded.
  vga_pix_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk_25_175),
    .rst     (reset),
    .flush_i (frame_start),
    .push_i  (inflight_q),
    .din_i   (mem_rdata),
    .pop_i   (pix_pop && !fifo_empty && !frame_start),
    .head_o  (fifo_head),
    .level_o (fifo_level),
    .empty_o (fifo_empty)
  );

  // Credit counts the in-flight read so a return always has a free slot.
  // No fetch is started in a frame_start cycle: its data would be stale.
  assign credit     = fifo_level + LW'(inflight_q);
  assign can_fetch  = (credit < LW'(FIFO_DEPTH)) && !frame_start;
  assign last_fetch = rd_en && (fetch_addr_q == ADDR_W'(FRAME_PIXELS - 1));

  always_comb begin
    rd_en = 1'b0;
    gnt   = 1'b0;
    case (state_q)
      ST_PREFILL: rd_en = can_fetch;
      ST_RUN: begin
        if (fifo_level <= LW'(LOW_WATER)) rd_en = can_fetch;
        else if (wr_req)                  gnt   = 1'b1;
        else                              rd_en = can_fetch;
      end
      ST_DONE: gnt = wr_req;
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FLUSH:   state_d = ST_PREFILL;
      ST_PREFILL: if (last_fetch) state_d = ST_DONE;
                  else if (fifo_level == LW'(FIFO_DEPTH)) state_d = ST_RUN;
      ST_RUN:     if (last_fetch) state_d = ST_DONE;
      default:    state_d = state_q;
    endcase
  end

  always_ff @(posedge clk_25_175 or posedge reset) begin
    if (reset) begin
      state_q      <= ST_FLUSH;
      fetch_addr_q <= '0;
      inflight_q   <= 1'b0;
      pix_q        <= '0;
      underrun_q   <= 1'b0;
    end else if (frame_start) begin
      state_q      <= ST_FLUSH;
      fetch_addr_q <= '0;
      inflight_q   <= 1'b0;
      pix_q        <= '0;
      underrun_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= rd_en;
      // The address parks on the last pixel instead of wrapping.
      if (rd_en && !last_fetch) fetch_addr_q <= fetch_addr_q + 1'b1;
      if (pix_pop) begin
        if (fifo_empty) begin
          pix_q      <= UNDERRUN_COLOR;
          underrun_q <= 1'b1;
        end else begin
          pix_q <= fifo_head;
        end
      end
    end
  end

`ifdef FB_UNDERRUN_COUNT_EN
  logic [15:0] ucnt_q;

  always_ff @(posedge clk_25_175 or posedge reset) begin
    if (reset)            ucnt_q <= '0;
    else if (frame_start) ucnt_q <= '0;
    else if (pix_pop && fifo_empty && (ucnt_q != 16'hFFFF))
      ucnt_q <= ucnt_q + 16'd1;
  end

  assign underrun_cnt = ucnt_q;
`endif

  assign mem_rd_en = rd_en;
  assign mem_wr_en = gnt;
  assign wr_gnt    = gnt;
  assign mem_addr  = gnt ? wr_addr : fetch_addr_q;
  assign mem_wdata = wr_data;
  assign pixstream = pix_q;
  assign underrun  = underrun_q;
  assign dbg_state = state_q;
  assign dbg_level = fifo_level;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb_vga_fb_arbiter: directed bench for vga_fb_arbiter with FRAME_PIXELS=16.
// The RAM model returns addr[11:0] one cycle after each read strobe.
// Expected pixels and expected read addresses are queued by the driver and
// consumed by a negedge monitor. Optional macro: FB_UNDERRUN_COUNT_EN.
module tb_vga_fb_arbiter;
  import vga_fb_pkg::*;

  localparam int ADDR_W = 19;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              frame_start = 1'b0;
  logic              pix_pop = 1'b0;
  logic [11:0]       pixstream;
  logic              underrun;
  logic              wr_req = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [11:0]       wr_data = '0;
  logic              wr_gnt;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en, mem_wr_en;
  logic [11:0]       mem_wdata;
  logic [11:0]       mem_rdata = '0;
`ifdef FB_UNDERRUN_COUNT_EN
  logic [15:0]       underrun_cnt;
`endif
  fb_state_e         dbg_state;
  logic [3:0]        dbg_level;

  int checks = 0;
  int errors = 0;
  logic [11:0]       exp_q[$];   // expected pixstream values, one per pop
  logic [ADDR_W-1:0] rd_q[$];    // expected read addresses in order
  logic              pop_v;

  vga_fb_arbiter #(
    .ADDR_W(ADDR_W), .FRAME_PIXELS(16), .FIFO_DEPTH(8), .LOW_WATER(2),
    .UNDERRUN_COLOR(12'h000)
  ) dut (
    .clk_25_175(clk), .reset(reset), .frame_start(frame_start),
    .pix_pop(pix_pop), .pixstream(pixstream), .underrun(underrun),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
`ifdef FB_UNDERRUN_COUNT_EN
    .underrun_cnt(underrun_cnt),
`endif
    .dbg_state(dbg_state), .dbg_level(dbg_level)
  );

  // ---------------- clock / reset / RAM model ----------------
  always #20 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= mem_addr[11:0];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_state(input fb_state_e tgt, input int budget);
    int n = 0;
    while (dbg_state !== tgt && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("wait_state", 32'(dbg_state), 32'(tgt));
  endtask

  // ---------------- monitor ----------------
  always @(posedge clk or posedge reset) begin
    if (reset) pop_v <= 1'b0;
    else       pop_v <= pix_pop && !frame_start;
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (pop_v) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL pixstream: got 0x%0h with no expected pixel queued", pixstream);
        end else begin
          chk("pixstream", 32'(pixstream), 32'(exp_q.pop_front()));
        end
      end
      if (mem_rd_en) begin
        if (rd_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rd_addr: unexpected read at 0x%0h, expected none", mem_addr);
        end else begin
          chk("rd_addr", 32'(mem_addr), 32'(rd_q.pop_front()));
        end
      end
      if (mem_rd_en || mem_wr_en) chk("one_ram_op", 32'(mem_rd_en & mem_wr_en), 32'd0);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_pixstream", 32'(pixstream), 32'h0);
    chk("rst_underrun",  32'(underrun),  32'h0);
    chk("rst_rd_en",     32'(mem_rd_en), 32'h0);
    chk("rst_wr_en",     32'(mem_wr_en), 32'h0);
    chk("rst_wr_gnt",    32'(wr_gnt),    32'h0);
    chk("rst_state",     32'(dbg_state), 32'(ST_FLUSH));
    chk("rst_level",     32'(dbg_level), 32'h0);

    // A: frame_start, no pops -> reads 0..7, level 8, RUN, then idle.
    @(posedge clk); #1;
    reset = 1'b0; frame_start = 1'b1;
    for (int a = 0; a < 8; a++) rd_q.push_back(ADDR_W'(a));
    @(posedge clk); #1;
    frame_start = 1'b0;
    @(negedge clk);
    wait_state(ST_RUN, 30);
    chk("prefill_level", 32'(dbg_level), 32'd8);
    repeat (4) @(negedge clk);
    chk("prefill_reads_done", 32'(rd_q.size()), 32'd0);

    // B: writer granted immediately at level 8.
    @(posedge clk); #1;
    wr_req = 1'b1; wr_addr = 19'h100; wr_data = 12'hABC;
    @(negedge clk);
    chk("b_wr_gnt",  32'(wr_gnt),    32'd1);
    chk("b_wr_en",   32'(mem_wr_en), 32'd1);
    chk("b_rd_en",   32'(mem_rd_en), 32'd0);
    chk("b_addr",    32'(mem_addr),  32'h100);
    chk("b_wdata",   32'(mem_wdata), 32'hABC);

    // C: 16 back-to-back pops with the writer still requesting.
    // Levels 8..3 grant the writer, levels <=2 fetch 8..15, then DONE.
    for (int a = 8; a < 16; a++) rd_q.push_back(ADDR_W'(a));
    for (int k = 0; k < 16; k++) begin
      @(posedge clk); #1;
      pix_pop = 1'b1;
      exp_q.push_back(12'(k));
      @(negedge clk);
      chk("c_wr_gnt", 32'(wr_gnt),    32'((k <= 5) || (k >= 14)));
      chk("c_rd_en",  32'(mem_rd_en), 32'((k >= 6) && (k <= 13)));
    end
    @(posedge clk); #1;
    pix_pop = 1'b0;
    @(negedge clk);
    chk("c_state_done", 32'(dbg_state), 32'(ST_DONE));
    chk("c_underrun",   32'(underrun),  32'd0);

    // DONE: wr_gnt follows wr_req, no fetches.
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      wr_req = (k % 2) == 1;
      wr_addr = ADDR_W'(k);
      @(negedge clk);
      chk("done_wr_gnt", 32'(wr_gnt),    32'(k % 2));
      chk("done_rd_en",  32'(mem_rd_en), 32'd0);
    end

    // E: frame_start then 10 pops; the first three see an empty FIFO.
    for (int a = 0; a < 10; a++) rd_q.push_back(ADDR_W'(a));
    @(posedge clk); #1;
    wr_req = 1'b0; frame_start = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      frame_start = 1'b0;
      pix_pop = 1'b1;
      exp_q.push_back((k <= 3) ? 12'h000 : 12'(k - 4));
      @(negedge clk);
      if (k == 1) chk("e_fs_pixstream", 32'(pixstream), 32'h0);
    end
    @(posedge clk); #1;
    pix_pop = 1'b0;
    @(negedge clk);
    chk("e_underrun", 32'(underrun),  32'd1);
    chk("e_rd_en",    32'(mem_rd_en), 32'd1);
`ifdef FB_UNDERRUN_COUNT_EN
    chk("e_underrun_cnt", 32'(underrun_cnt), 32'd3);
`endif

    // D: frame_start the cycle after a read issues; its data is dropped.
    @(posedge clk); #1;
    frame_start = 1'b1;
    @(negedge clk);
    chk("d_fs_rd_en", 32'(mem_rd_en), 32'd0);
    @(posedge clk); #1;
    frame_start = 1'b0;
    for (int a = 0; a < 8; a++) rd_q.push_back(ADDR_W'(a));
    @(negedge clk);
    chk("d_underrun",  32'(underrun),  32'd0);
    chk("d_level",     32'(dbg_level), 32'd0);
    chk("d_pixstream", 32'(pixstream), 32'h0);
`ifdef FB_UNDERRUN_COUNT_EN
    chk("d_underrun_cnt", 32'(underrun_cnt), 32'd0);
`endif
    wait_state(ST_RUN, 30);
    chk("d_level_full", 32'(dbg_level), 32'd8);

    // Pop the refill: pixels 0..7 prove the dropped return never landed.
    for (int a = 8; a < 12; a++) rd_q.push_back(ADDR_W'(a));
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      wr_req = 1'b1; wr_addr = 19'h055; wr_data = 12'h123;
      pix_pop = 1'b1;
      exp_q.push_back(12'(k));
    end
    @(posedge clk); #1;
    pix_pop = 1'b0;
    repeat (6) @(negedge clk);
    chk("d_wr_gnt_end",  32'(wr_gnt),       32'd1);
    chk("end_rd_q",      32'(rd_q.size()),  32'd0);
    chk("end_exp_q",     32'(exp_q.size()), 32'd0);
    chk("end_underrun",  32'(underrun),     32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
